// File: rtl/digit_buffer_tx_pkg.sv
// rtl/digit_buffer_tx_pkg.sv - shared constants, state type and ASCII helper for digit_buffer_tx
package digit_buffer_tx_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        TERM_CR,
        TERM_LF,
        DONE
    } dtx_state_t;

    // Map a nibble to its uppercase ASCII hex character ('0'-'9', 'A'-'F').
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/digit_buffer_tx_if.sv
// rtl/digit_buffer_tx_if.sv - byte handshake between digit_buffer_tx and uart_tx
interface digit_buffer_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/digit_buffer_tx.sv
// rtl/digit_buffer_tx.sv - snapshot the display buffer and stream it as one line; DIGIT_TX_HEX_EN selects ASCII hex output
module digit_buffer_tx
    import digit_buffer_tx_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter bit SEND_CRLF      = 1'b1,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [8*N_DIGITS-1:0] digits,
    digit_buffer_tx_if.master     tx,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    localparam int IDX_W = $clog2(N_DIGITS) + 1;
    localparam int SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

    dtx_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       snap_q [N_DIGITS];
    logic [7:0]       snap_d [N_DIGITS];
    logic             tmo_err_q, tmo_err_d;
`ifdef DIGIT_TX_HEX_EN
    logic             nib_q, nib_d;
`endif

    logic [7:0] cur_byte;
    logic [7:0] data_c;
    logic       valid_c;
    logic       xfer;
    logic       stall;

    // Next-state, datapath and handshake/timeout decisions for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        snap_d    = snap_q;
        tmo_err_d = 1'b0;
        valid_c   = 1'b0;
        data_c    = '0;
`ifdef DIGIT_TX_HEX_EN
        nib_d     = nib_q;
`endif
        cur_byte  = snap_q[idx_q[SEL_W-1:0]];

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    snap_d[i] = digits[8*i +: 8];
                end
                idx_d   = '0;
                tmo_d   = '0;
`ifdef DIGIT_TX_HEX_EN
                nib_d   = 1'b0;
`endif
                state_d = SEND;
            end
            SEND: begin
                valid_c = 1'b1;
`ifdef DIGIT_TX_HEX_EN
                data_c  = nib_q ? nibble_to_ascii(cur_byte[3:0]) : nibble_to_ascii(cur_byte[7:4]);
`else
                data_c  = cur_byte;
`endif
            end
            TERM_CR: begin
                valid_c = 1'b1;
                data_c  = ASCII_CR;
            end
            TERM_LF: begin
                valid_c = 1'b1;
                data_c  = ASCII_LF;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        xfer  = valid_c & tx.tx_ready;
        stall = valid_c & ~tx.tx_ready;

        if (xfer) begin
            tmo_d = '0;
            case (state_q)
                SEND: begin
`ifdef DIGIT_TX_HEX_EN
                    if (!nib_q) begin
                        nib_d = 1'b1;
                    end else begin
                        nib_d = 1'b0;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            if (SEND_CRLF) state_d = TERM_CR;
                            else           state_d = DONE;
                        end
                    end
`else
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        if (SEND_CRLF) state_d = TERM_CR;
                        else           state_d = DONE;
                    end
`endif
                end
                TERM_CR: state_d = TERM_LF;
                TERM_LF: state_d = DONE;
                default: ;
            endcase
        end else if (stall && TMO_EN) begin
            // The receiver stalled for the whole budget: abandon the frame.
            if (tmo_q == TMO_LIMIT) begin
                tmo_err_d = 1'b1;
                tmo_d     = '0;
                state_d   = IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // State, snapshot and counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                snap_q[i] <= '0;
            end
`ifdef DIGIT_TX_HEX_EN
            nib_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
            snap_q    <= snap_d;
`ifdef DIGIT_TX_HEX_EN
            nib_q     <= nib_d;
`endif
        end
    end

    assign tx.tx_valid = valid_c;
    assign tx.tx_data  = data_c;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_digit_buffer_tx.sv
// tb/tb_digit_buffer_tx.sv - randomized self-checking bench for digit_buffer_tx against a frame-level model
module tb_digit_buffer_tx;

    localparam int NA = 8;
    localparam int TA = 16;
    localparam int NB = 2;

    logic clk = 1'b0;
    logic rstn;
    logic start_a, start_b;
    logic [8*NA-1:0] digits_a;
    logic [8*NB-1:0] digits_b;
    logic busy_a, done_a, tmo_a;
    logic busy_b, done_b, tmo_b;

    digit_buffer_tx_if bus_a();
    digit_buffer_tx_if bus_b();

    digit_buffer_tx #(.N_DIGITS(NA), .SEND_CRLF(1'b1), .TIMEOUT_CYCLES(TA)) u_dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .digits(digits_a), .tx(bus_a),
        .busy(busy_a), .done(done_a), .timeout_err(tmo_a)
    );

    digit_buffer_tx #(.N_DIGITS(NB), .SEND_CRLF(1'b0), .TIMEOUT_CYCLES(0)) u_dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .digits(digits_b), .tx(bus_b),
        .busy(busy_b), .done(done_b), .timeout_err(tmo_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int first_valid, busy_cyc, done_cnt, tmo_cnt, tmo_cyc, stab_bad, valid_cnt;
    logic tmo_v, tmo_busy;
    bit expired;

    // Expected line: each character raw (or as two uppercase hex chars), then optional CR LF.
    task automatic build_expected(input logic [127:0] dig, input int n, input bit crlf);
        logic [7:0] b;
`ifdef DIGIT_TX_HEX_EN
        string s;
`endif
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            b = dig[8*i +: 8];
`ifdef DIGIT_TX_HEX_EN
            s = $sformatf("%02X", b);
            exp_q.push_back(s[0]);
            exp_q.push_back(s[1]);
`else
            exp_q.push_back(b);
`endif
        end
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    // Pulse start, drive tx_ready per rmode and record everything the DUT does.
    // rmode: 0 always ready, 1 one-in-four, 2 random with bounded stalls, 3 never, 4 ready from cycle 40.
    task automatic capture(input int which, input int rmode, input bit disturb, input int budget);
        int tail, zrun, phase;
        bit prev_stall, st, rdy;
        logic [7:0] prev_data, d;
        logic v, b, dn, te;
        got_q.delete();
        first_valid = -1; busy_cyc = 0; done_cnt = 0; tmo_cnt = 0; tmo_cyc = -1;
        stab_bad = 0; valid_cnt = 0; expired = 1'b1; tmo_v = 1'b0; tmo_busy = 1'b0;
        tail = -1; zrun = 0; prev_stall = 1'b0; prev_data = '0;
        phase = $urandom_range(0, 3);
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            st = (t == 0) || (disturb && t >= 3 && done_cnt == 0);
            case (rmode)
                0: rdy = 1'b1;
                1: rdy = ((t + phase) % 4 == 0);
                2: rdy = (zrun >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
                3: rdy = 1'b0;
                default: rdy = (t >= 40);
            endcase
            zrun = rdy ? 0 : zrun + 1;
            if (which == 0) begin
                start_a = st;
                bus_a.tx_ready = rdy;
                if (disturb && t == 4) digits_a = {NA{8'h20}};
            end else begin
                start_b = st;
                bus_b.tx_ready = rdy;
                if (disturb && t == 4) digits_b = {NB{8'h20}};
            end
            #1;
            if (which == 0) begin
                v = bus_a.tx_valid; d = bus_a.tx_data; b = busy_a; dn = done_a; te = tmo_a;
            end else begin
                v = bus_b.tx_valid; d = bus_b.tx_data; b = busy_b; dn = done_b; te = tmo_b;
            end
            if (v) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = t;
            end
            if (prev_stall && (!v || d !== prev_data)) stab_bad++;
            if (v && rdy) got_q.push_back(d);
            prev_stall = v && !rdy;
            prev_data = d;
            if (b) busy_cyc++;
            if (dn) done_cnt++;
            if (te) begin
                tmo_cnt++;
                tmo_cyc = t;
                tmo_v = v;
                tmo_busy = b;
            end
            if ((dn || te) && tail < 0) tail = 6;
            if (tail > 0) begin
                tail--;
                if (tail == 0) begin
                    expired = 1'b0;
                    break;
                end
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        bus_a.tx_ready = 1'b0;
        bus_b.tx_ready = 1'b0;
    endtask

    task automatic set_hello();
        string s;
        s = "HELLO123";
        for (int i = 0; i < NA; i++) digits_a[8*i +: 8] = s[i];
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({bus_a.tx_valid, busy_a, done_a, tmo_a} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_a: valid/busy/done/tmo=%b required 0000", {bus_a.tx_valid, busy_a, done_a, tmo_a});
        end
        n_cmp++;
        if ({bus_b.tx_valid, busy_b, done_b, tmo_b} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_b: valid/busy/done/tmo=%b required 0000", {bus_b.tx_valid, busy_b, done_b, tmo_b});
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({bus_a.tx_valid, busy_a, done_a, tmo_a} !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_after_reset: valid/busy/done/tmo=%b required 0000", {bus_a.tx_valid, busy_a, done_a, tmo_a});
        end
    endtask

    task automatic test_hello();
        int dpos;
        set_hello();
        build_expected(128'(digits_a), NA, 1'b1);
        capture(0, 0, 1'b0, 200);
        dpos = -1;
        if (got_q.size() != exp_q.size()) dpos = 0;
        else foreach (exp_q[i]) if (dpos < 0 && got_q[i] !== exp_q[i]) dpos = i;
        n_cmp++;
        if (dpos >= 0 || expired) begin
            n_bad++;
            $display("FAIL hello_seq: got %0d bytes need %0d, first diff %0d, expired %0d", got_q.size(), exp_q.size(), dpos, expired);
        end
        n_cmp++;
        if (first_valid != 2) begin
            n_bad++;
            $display("FAIL hello_latency: first valid at %0d required 2", first_valid);
        end
        n_cmp++;
        if (busy_cyc != exp_q.size() + 2) begin
            n_bad++;
            $display("FAIL hello_busy: busy %0d cycles required %0d", busy_cyc, exp_q.size() + 2);
        end
        n_cmp++;
        if (valid_cnt != exp_q.size()) begin
            n_bad++;
            $display("FAIL hello_back_to_back: valid %0d cycles required %0d", valid_cnt, exp_q.size());
        end
        n_cmp++;
        if (done_cnt != 1 || tmo_cnt != 0) begin
            n_bad++;
            $display("FAIL hello_done: done %0d timeout %0d required 1 and 0", done_cnt, tmo_cnt);
        end
    endtask

    task automatic test_ready_throttle();
        int dpos;
        set_hello();
        build_expected(128'(digits_a), NA, 1'b1);
        capture(0, 1, 1'b0, 300);
        dpos = -1;
        if (got_q.size() != exp_q.size()) dpos = 0;
        else foreach (exp_q[i]) if (dpos < 0 && got_q[i] !== exp_q[i]) dpos = i;
        n_cmp++;
        if (dpos >= 0 || expired) begin
            n_bad++;
            $display("FAIL throttle_seq: got %0d bytes need %0d, first diff %0d, expired %0d", got_q.size(), exp_q.size(), dpos, expired);
        end
        n_cmp++;
        if (stab_bad != 0) begin
            n_bad++;
            $display("FAIL throttle_stable: %0d unstable stall cycles required 0", stab_bad);
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_bad++;
            $display("FAIL throttle_done: done %0d required 1", done_cnt);
        end
    endtask

    task automatic test_restart_snapshot();
        int dpos;
        set_hello();
        build_expected(128'(digits_a), NA, 1'b1);
        capture(0, 2, 1'b1, 300);
        dpos = -1;
        if (got_q.size() != exp_q.size()) dpos = 0;
        else foreach (exp_q[i]) if (dpos < 0 && got_q[i] !== exp_q[i]) dpos = i;
        n_cmp++;
        if (dpos >= 0 || expired) begin
            n_bad++;
            $display("FAIL snapshot_seq: got %0d bytes need %0d, first diff %0d, expired %0d", got_q.size(), exp_q.size(), dpos, expired);
        end
        n_cmp++;
        if (done_cnt != 1 || busy_a !== 1'b0 || bus_a.tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_ignored: done %0d busy %b valid %b required 1 0 0", done_cnt, busy_a, bus_a.tx_valid);
        end
    endtask

    task automatic test_timeout();
        set_hello();
        capture(0, 3, 1'b0, 100);
        n_cmp++;
        if (tmo_cnt != 1 || expired) begin
            n_bad++;
            $display("FAIL timeout_pulse: %0d pulses (expired %0d) required 1", tmo_cnt, expired);
        end
        n_cmp++;
        if (tmo_cyc - first_valid != TA) begin
            n_bad++;
            $display("FAIL timeout_delay: %0d cycles after valid rose required %0d", tmo_cyc - first_valid, TA);
        end
        n_cmp++;
        if (valid_cnt != TA || tmo_v !== 1'b0 || tmo_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_abort: valid %0d cycles, valid %b busy %b at pulse; required %0d 0 0", valid_cnt, tmo_v, tmo_busy, TA);
        end
        n_cmp++;
        if (done_cnt != 0 || got_q.size() != 0) begin
            n_bad++;
            $display("FAIL timeout_nodone: done %0d bytes %0d required 0 0", done_cnt, got_q.size());
        end
    endtask

    task automatic test_timeout_disabled();
        int dpos;
        digits_b = {8'h5A, 8'hC3};
        build_expected(128'(digits_b), NB, 1'b0);
        capture(1, 4, 1'b0, 200);
        dpos = -1;
        if (got_q.size() != exp_q.size()) dpos = 0;
        else foreach (exp_q[i]) if (dpos < 0 && got_q[i] !== exp_q[i]) dpos = i;
        n_cmp++;
        if (dpos >= 0 || expired || tmo_cnt != 0 || stab_bad != 0) begin
            n_bad++;
            $display("FAIL no_timeout: bytes %0d need %0d diff %0d tmo %0d unstable %0d expired %0d", got_q.size(), exp_q.size(), dpos, tmo_cnt, stab_bad, expired);
        end
    endtask

    task automatic test_hex_pattern();
        int dpos;
        digits_b = {8'hA5, 8'h3C};
        build_expected(128'(digits_b), NB, 1'b0);
        capture(1, 0, 1'b0, 100);
        dpos = -1;
        if (got_q.size() != exp_q.size()) dpos = 0;
        else foreach (exp_q[i]) if (dpos < 0 && got_q[i] !== exp_q[i]) dpos = i;
        n_cmp++;
        if (dpos >= 0 || expired) begin
            n_bad++;
            $display("FAIL short_frame_seq: got %0d bytes need %0d, first diff %0d", got_q.size(), exp_q.size(), dpos);
        end
        n_cmp++;
        if (busy_cyc != exp_q.size() + 2 || first_valid != 2) begin
            n_bad++;
            $display("FAIL short_frame_timing: busy %0d first valid %0d required %0d 2", busy_cyc, first_valid, exp_q.size() + 2);
        end
    endtask

    task automatic test_reset_mid_frame();
        int dpos;
        set_hello();
        build_expected(128'(digits_a), NA, 1'b1);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            start_a = (t == 0);
            bus_a.tx_ready = 1'b1;
            #1;
            if (t == 5) begin
                n_cmp++;
                if (bus_a.tx_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL midframe_valid: valid %b required 1", bus_a.tx_valid);
                end
                rstn = 1'b0;
                #1;
                n_cmp++;
                if ({bus_a.tx_valid, busy_a, done_a, tmo_a} !== 4'b0000) begin
                    n_bad++;
                    $display("FAIL async_reset: valid/busy/done/tmo=%b required 0000", {bus_a.tx_valid, busy_a, done_a, tmo_a});
                end
                break;
            end
        end
        bus_a.tx_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        capture(0, 0, 1'b0, 200);
        dpos = -1;
        if (got_q.size() != exp_q.size()) dpos = 0;
        else foreach (exp_q[i]) if (dpos < 0 && got_q[i] !== exp_q[i]) dpos = i;
        n_cmp++;
        if (dpos >= 0 || expired || first_valid != 2 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL after_reset_frame: bytes %0d need %0d diff %0d first %0d done %0d", got_q.size(), exp_q.size(), dpos, first_valid, done_cnt);
        end
    endtask

    task automatic test_random();
        int dpos;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                for (int i = 0; i < NA; i++) digits_a[8*i +: 8] = 8'($urandom_range(0, 255));
                build_expected(128'(digits_a), NA, 1'b1);
                capture(0, 2, 1'b0, 300);
            end else begin
                for (int i = 0; i < NB; i++) digits_b[8*i +: 8] = 8'($urandom_range(0, 255));
                build_expected(128'(digits_b), NB, 1'b0);
                capture(1, 2, 1'b0, 300);
            end
            dpos = -1;
            if (got_q.size() != exp_q.size()) dpos = 0;
            else foreach (exp_q[i]) if (dpos < 0 && got_q[i] !== exp_q[i]) dpos = i;
            n_cmp++;
            if (dpos >= 0 || expired || done_cnt != 1 || stab_bad != 0) begin
                n_bad++;
                $display("FAIL random_%0d: bytes %0d need %0d diff %0d done %0d unstable %0d expired %0d", k, got_q.size(), exp_q.size(), dpos, done_cnt, stab_bad, expired);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        digits_a = '0;
        digits_b = '0;
        bus_a.tx_ready = 1'b0;
        bus_b.tx_ready = 1'b0;
        test_reset();
        test_hello();
        test_ready_throttle();
        test_restart_snapshot();
        test_timeout();
        test_timeout_disabled();
        test_hex_pattern();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
